// File: rtl/qlf_k6n10f_wide_add_pkg.sv
// ---------------------------------------------------------------------------
// qlf_k6n10f_wide_add_pkg
// Shared types for the wide add/sub scheduler:
//   state_t  - scheduler FSM state (IDLE -> RUN -> DONE -> IDLE)
//   req_id_t - requester index carried with each operation
//   idx_w()  - width of the word index counter for a given word count
// ---------------------------------------------------------------------------
package qlf_k6n10f_wide_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  // $clog2 of the word count, kept at least 1 bit wide.
  function automatic int idx_w(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/qlf_k6n10f_word_adder.sv
// ---------------------------------------------------------------------------
// qlf_k6n10f_word_adder
// Combinational WORD_W-bit ripple carry slice: one full-adder carry cell per
// bit, chained LSB to MSB, mirroring one pass through a hard carry column.
// Ports:
//   cin     - carry into bit 0
//   a, b    - operand words
//   sum     - a + b + cin (mod 2^WORD_W)
//   cout    - carry out of the MSB
//   msb_cin - carry into the MSB (only with QLF_WIDE_ADD_SCHED_OVF_EN)
// ---------------------------------------------------------------------------
module qlf_k6n10f_word_adder #(
  parameter int WORD_W = 8
) (
  input  logic              cin,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              cout
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  ,
  output logic              msb_cin
`endif
);

  logic [WORD_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WORD_W; i++) begin : g_cell
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[WORD_W];

`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  assign msb_cin = w_c[WORD_W-1];
`endif

endmodule

// File: rtl/qlf_k6n10f_wide_add_sched.sv
// ---------------------------------------------------------------------------
// qlf_k6n10f_wide_add_sched
// Shares one WORD_W-bit carry slice between two requesters, performing a
// DATA_W = WORD_W*NUM_WORDS add/sub one word per cycle, LSW first.
// Optional feature macro: QLF_WIDE_ADD_SCHED_OVF_EN adds rsp_ovf.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   reqN_valid/ready/a/b/sub   - requester N operation (N = 0, 1)
//   rsp_valid/ready            - result handshake
//   rsp_id, rsp_y, rsp_co      - owner, result word, carry out of MSB
//   dbg_state                  - current FSM state
//   rsp_ovf                    - signed overflow (optional)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. reqN_ready is combinational and only high in IDLE for the
// granted requester; rsp_valid, once high, holds rsp_* stable until
// rsp_ready is seen.
// ---------------------------------------------------------------------------
module qlf_k6n10f_wide_add_sched
  import qlf_k6n10f_wide_add_pkg::*;
#(
  parameter  int WORD_W    = 8,
  parameter  int NUM_WORDS = 4,
  localparam int DATA_W    = WORD_W * NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_co,
  output state_t            dbg_state
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  localparam int IDX_W = idx_w(NUM_WORDS);

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;      // already inverted for subtract
  req_id_t             r_id;
  logic                r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic                r_rr;     // 1 = requester 1 preferred on a tie
  logic                r_valid;
  logic [DATA_W-1:0]   r_y;
  logic                r_co;

  logic                w_idle;
  logic                w_grant0;
  logic                w_grant1;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic                w_sub;
  logic [WORD_W-1:0]   w_sum;
  logic                w_cout;
  logic                w_last;

  // Ready is gated by reset so no handshake can be seen while held in reset.
  assign w_idle   = (r_state == ST_IDLE) && !reset;
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || r_rr);
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_rr);

  assign w_a   = w_grant1 ? req1_a   : req0_a;
  assign w_b   = w_grant1 ? req1_b   : req0_b;
  assign w_sub = w_grant1 ? req1_sub : req0_sub;

  assign w_last = (r_idx == IDX_W'(NUM_WORDS - 1));

`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  logic w_msb_cin;
  logic r_ovf;
`endif

  qlf_k6n10f_word_adder #(.WORD_W(WORD_W)) u_slice (
    .cin     (r_carry),
    .a       (r_a[r_idx*WORD_W +: WORD_W]),
    .b       (r_b[r_idx*WORD_W +: WORD_W]),
    .sum     (w_sum),
    .cout    (w_cout)
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
    ,
    .msb_cin (w_msb_cin)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_rr    <= 1'b0;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_co    <= 1'b0;
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_a     <= w_a;
            r_b     <= w_sub ? ~w_b : w_b;
            r_carry <= w_sub;   // A + ~B + 1 for subtract
            r_id    <= w_grant1;
            r_idx   <= '0;
            r_state <= ST_RUN;
            if (req0_valid && req1_valid) r_rr <= ~r_rr;
          end
        end
        ST_RUN: begin
          r_y[r_idx*WORD_W +: WORD_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_co    <= w_cout;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
            r_ovf   <= w_msb_cin ^ w_cout;
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_y      = r_y;
  assign rsp_co     = r_co;
  assign dbg_state  = r_state;
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  assign rsp_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_qlf_k6n10f_wide_add_sched.sv
// ---------------------------------------------------------------------------
// tb_qlf_k6n10f_wide_add_sched
// Directed vectors with hand-computed results for the wide add scheduler.
// ---------------------------------------------------------------------------
module tb_qlf_k6n10f_wide_add_sched;
  import qlf_k6n10f_wide_add_pkg::*;

  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = 4;
  localparam int DATA_W    = WORD_W * NUM_WORDS;
  localparam int LAT       = NUM_WORDS + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req0_valid, req0_ready, req0_sub;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready, req1_sub;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_co;
  logic [DATA_W-1:0] rsp_y;
  state_t            dbg_state;
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
  logic              rsp_ovf;
`endif

  qlf_k6n10f_wide_add_sched #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_co     (rsp_co),
    .dbg_state  (dbg_state)
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // ---------------- scoreboard counters / checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int which, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic sub);
    if (which == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  // Returns with time at negedge+1 of the cycle in which a ready was seen.
  task automatic wait_grant(output int which);
    which = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready) begin which = 0; break; end
      if (req1_ready) begin which = 1; break; end
      @(negedge clk);
    end
    if (which < 0) check_eq("grant_timeout", 64'd0, 64'd1);
  endtask

  // Counts negedges from the grant cycle until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input string tag, input int which, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic sub,
                       input logic [DATA_W-1:0] exp_y, input logic exp_co, input logic exp_ovf);
    int g;
    int lat;
    set_req(which, a, b, sub);
    wait_grant(g);
    check_eq({tag, "_grant"}, 64'(g), 64'(which));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(LAT));
    check_eq({tag, "_y"},   64'(rsp_y), 64'(exp_y));
    check_eq({tag, "_co"},  64'(rsp_co), 64'(exp_co));
    check_eq({tag, "_id"},  64'(rsp_id), 64'(which));
`ifdef QLF_WIDE_ADD_SCHED_OVF_EN
    check_eq({tag, "_ovf"}, 64'(rsp_ovf), 64'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    @(negedge clk); #1;
    check_eq({tag, "_idle"}, 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int lat;
    int early;
    logic [DATA_W-1:0] held_y;

    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_y",     64'(rsp_y), 64'd0);
    check_eq("rst_co",    64'(rsp_co), 64'd0);
    check_eq("rst_id",    64'(rsp_id), 64'd0);
    check_eq("rst_rdy",   64'({req0_ready, req1_ready}), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Basic add / subtract / wrap
    do_op("add_ff",  0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op("sub_brw", 1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("sub_5_3", 1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    do_op("wrap",    0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("ovf",     0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Arbitration: both valid continuously -> grants 0,1,0,1
    set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    set_req(1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check_eq($sformatf("arb_grant%0d", k), 64'(g), 64'(k % 2));
      wait_rsp(lat);
      check_eq($sformatf("arb_id%0d", k), 64'(rsp_id), 64'(k % 2));
      check_eq($sformatf("arb_y%0d", k), 64'(rsp_y),
               (k % 2 == 1) ? 64'h7FFF_FFFF : 64'h2345_6789);
      check_eq($sformatf("arb_co%0d", k), 64'(rsp_co), (k % 2 == 1) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Pointer now prefers 0, but only requester 1 asks
    do_op("only1", 1, 32'h0000_00F0, 32'h0000_0010, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    // Backpressure: hold DONE for 10 cycles with a new request waiting
    rsp_ready = 1'b0;
    set_req(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
    wait_grant(g);
    check_eq("bp_grant", 64'(g), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(lat);
    check_eq("bp_lat", 64'(lat), 64'(LAT));
    held_y = 32'h0100_0100;
    set_req(0, 32'h0000_0002, 32'h0000_0003, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
      check_eq($sformatf("bp_y%0d", i), 64'(rsp_y), 64'(held_y));
      check_eq($sformatf("bp_rdy%0d", i), 64'(req0_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("bp_release_valid", 64'(rsp_valid), 64'd0);
    check_eq("bp_release_rdy",   64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(lat);
    check_eq("bp_next_lat", 64'(lat), 64'(LAT));
    check_eq("bp_next_y",   64'(rsp_y), 64'd5);
    @(negedge clk);

    // Reset in the middle of RUN (word index 2)
    set_req(1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    wait_grant(g);
    check_eq("mid_grant", 64'(g), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_state_run", 64'(dbg_state), 64'(ST_RUN));
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_y",     64'(rsp_y), 64'd0);
    check_eq("mid_rst_co",    64'(rsp_co), 64'd0);
    check_eq("mid_rst_id",    64'(rsp_id), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("mid_rst_rdy",   64'(req1_ready), 64'd0);
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) early++;
    end
    check_eq("mid_no_rsp", 64'(early), 64'd0);
    do_op("after_rst", 1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
